action_selector: RTL and testbench

- Downstream consumer of the control unit's action-select decision (1 = explore/random, 0 = exploit/greedy) in the RL learning SoC.
- On each start request, emits one action index for the agent.
  - Explore: index taken from the random value.
  - Exploit: sequential signed argmax over the current state's Q-values, one comparison per cycle.
- Result drives the agent/environment stage; optional max-Q output feeds the Q-update datapath.

---
 rtl/action_selector.sv | 156 +++++++++++++++
 tb/tb_action_selector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/action_selector.sv
// ============================================================================
// Module   : action_selector
// Brief    : Explore/exploit action picker: random index or sequential signed
//            argmax over latched Q-values. Optional macro MAX_Q_OUT_EN adds
//            the max_q_out port and forces a full scan on both paths.
// Revision : 1.0
// ============================================================================
`default_nettype none

module action_selector #(
  parameter int NUM_ACT = 4,
  parameter int Q_W     = 16,
  parameter int ACT_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   act_select_in,
  input  logic [9:0]             rand_in,
  input  logic [NUM_ACT*Q_W-1:0] q_vec_in,
  output logic                   busy,
  output logic                   act_valid,
`ifdef MAX_Q_OUT_EN
  output logic [Q_W-1:0]         max_q_out,
`endif
  output logic [ACT_W-1:0]       act_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [NUM_ACT*Q_W-1:0]   qv_q, qv_d;
  logic signed [Q_W-1:0]    best_q, best_d;
  logic [ACT_W-1:0]         idx_q, idx_d;
  logic [ACT_W-1:0]         cnt_q, cnt_d;
  logic [ACT_W-1:0]         act_q, act_d;
`ifdef MAX_Q_OUT_EN
  logic                     sel_q, sel_d;
  logic [ACT_W-1:0]         rand_q, rand_d;
  logic signed [Q_W-1:0]    maxq_q, maxq_d;
`endif

  // Only the low ACT_W bits of the random source select an action.
  logic w_unused_rand;
  assign w_unused_rand = ^rand_in[9:ACT_W];

  logic signed [Q_W-1:0] w_q_arr [NUM_ACT];
  for (genvar gi = 0; gi < NUM_ACT; gi++) begin : g_unpack
    assign w_q_arr[gi] = qv_q[gi*Q_W +: Q_W];
  end

  logic signed [Q_W-1:0] w_cand, w_best_nx;
  logic [ACT_W-1:0]      w_idx_nx;
  logic                  w_take;

  // Strict compare keeps the earliest index on ties.
  assign w_cand    = w_q_arr[cnt_q];
  assign w_take    = w_cand > best_q;
  assign w_best_nx = w_take ? w_cand : best_q;
  assign w_idx_nx  = w_take ? cnt_q  : idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      qv_q    <= '0;
      best_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      act_q   <= '0;
`ifdef MAX_Q_OUT_EN
      sel_q   <= 1'b0;
      rand_q  <= '0;
      maxq_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      qv_q    <= qv_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
`ifdef MAX_Q_OUT_EN
      sel_q   <= sel_d;
      rand_q  <= rand_d;
      maxq_q  <= maxq_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    qv_d      = qv_q;
    best_d    = best_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    act_d     = act_q;
`ifdef MAX_Q_OUT_EN
    sel_d     = sel_q;
    rand_d    = rand_q;
    maxq_d    = maxq_q;
`endif
    busy      = (state_q != S_IDLE);
    act_valid = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          qv_d   = q_vec_in;
          best_d = $signed(q_vec_in[Q_W-1:0]);
          idx_d  = '0;
          cnt_d  = ACT_W'(1);
`ifdef MAX_Q_OUT_EN
          sel_d   = act_select_in;
          rand_d  = rand_in[ACT_W-1:0];
          state_d = S_SCAN;
`else
          if (act_select_in) begin
            act_d   = rand_in[ACT_W-1:0];
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
          end
`endif
        end
      end
      S_SCAN: begin
        best_d = w_best_nx;
        idx_d  = w_idx_nx;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == ACT_W'(NUM_ACT - 1)) begin
          state_d = S_DONE;
`ifdef MAX_Q_OUT_EN
          act_d   = sel_q ? rand_q : w_idx_nx;
          maxq_d  = w_best_nx;
`else
          act_d   = w_idx_nx;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign act_out = act_q;
`ifdef MAX_Q_OUT_EN
  assign max_q_out = maxq_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_action_selector.sv
// ============================================================================
// Module   : tb_action_selector
// Brief    : Directed scoreboard bench for action_selector (both builds of
//            MAX_Q_OUT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_action_selector;

  localparam int NUM_ACT = 4;
  localparam int Q_W     = 16;
  localparam int ACT_W   = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   act_select_in;
  logic [9:0]             rand_in;
  logic [NUM_ACT*Q_W-1:0] q_vec_in;
  logic                   busy;
  logic                   act_valid;
  logic [ACT_W-1:0]       act_out;
`ifdef MAX_Q_OUT_EN
  logic [Q_W-1:0]         max_q_out;
`endif

  action_selector #(.NUM_ACT(NUM_ACT), .Q_W(Q_W), .ACT_W(ACT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .act_select_in (act_select_in),
    .rand_in       (rand_in),
    .q_vec_in      (q_vec_in),
    .busy          (busy),
    .act_valid     (act_valid),
`ifdef MAX_Q_OUT_EN
    .max_q_out     (max_q_out),
`endif
    .act_out       (act_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int act;
    int maxq;
    int lat;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference: first strictly-greater element wins.
  function automatic void model(input int qa[4], output int am, output int mx);
    am = 0;
    mx = qa[0];
    for (int i = 1; i < 4; i++) begin
      if (qa[i] > mx) begin
        mx = qa[i];
        am = i;
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge one cycle after the start edge.
  task automatic do_start(input bit sel, input logic [9:0] r,
                          input int q0, input int q1, input int q2, input int q3,
                          input bit push);
    int   qa[4];
    int   am, mx;
    exp_t e;
    qa = '{q0, q1, q2, q3};
    model(qa, am, mx);
    for (int i = 0; i < 4; i++) q_vec_in[i*Q_W +: Q_W] = qa[i][Q_W-1:0];
    act_select_in = sel;
    rand_in       = r;
    start         = 1'b1;
    e.act  = sel ? int'(r[ACT_W-1:0]) : am;
    e.maxq = mx;
`ifdef MAX_Q_OUT_EN
    e.lat  = 4;
`else
    e.lat  = sel ? 1 : 4;
`endif
    if (push) sb.push_back(e);
    @(negedge clk);
    start         = 1'b0;
    act_select_in = 1'($urandom);
    rand_in       = 10'($urandom);
    q_vec_in      = {$urandom, $urandom};
  endtask

  // Waits for the pulse, checks it against the scoreboard head, then steps one
  // cycle past it. With noise, start pulses are fired while the DUT is busy.
  task automatic wait_result(input string tag, input bit noise);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    e = sb.pop_front();
    for (int k = 1; k <= 20 && !seen; k++) begin
      if (act_valid === 1'b1) begin
        seen  = 1'b1;
        start = 1'b0;
        check({tag, "_lat"}, k, e.lat);
        check({tag, "_act"}, act_out, e.act);
`ifdef MAX_Q_OUT_EN
        check({tag, "_maxq"}, $signed(max_q_out), e.maxq);
`endif
        @(negedge clk);
        check({tag, "_pulse1"}, act_valid, 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_hold"}, act_out, e.act);
      end else begin
        check({tag, "_busy"}, busy, 1);
        if (noise) begin
          start         = 1'b1;
          act_select_in = 1'b1;
          rand_in       = 10'($urandom);
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({tag, "_seen"}, seen, 1);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    act_select_in = 1'b0;
    rand_in       = '0;
    q_vec_in      = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  busy, 0);
    check("rst_valid", act_valid, 0);
    check("rst_act",   act_out, 0);
`ifdef MAX_Q_OUT_EN
    check("rst_maxq",  max_q_out, 0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_busy",  busy, 0);
      check("idle_valid", act_valid, 0);
      check("idle_act",   act_out, 0);
    end

    do_start(1'b0, 10'h0, 5, -3, 12, 12, 1'b1);
    wait_result("greedy_tie", 1'b0);

    do_start(1'b0, 10'h0, -100, -2, -50, -7, 1'b1);
    wait_result("greedy_neg", 1'b0);

    do_start(1'b1, 10'h1FE, 1, 7, -4, 3, 1'b1);
    wait_result("rand_1fe", 1'b0);

    do_start(1'b1, 10'h201, -9, -20, 30, 2, 1'b1);
    wait_result("rand_201", 1'b0);

    do_start(1'b0, 10'h3FF, 0, 3, 3, -1, 1'b1);
    wait_result("busy_ign", 1'b1);

    do_start(1'b0, 10'h0, -1, 4, -1, 9, 1'b1);
    wait_result("b2b", 1'b0);

    do_start(1'b0, 10'h0, 1, 2, 3, 4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy",  busy, 0);
    check("midrst_valid", act_valid, 0);
    check("midrst_act",   act_out, 0);
`ifdef MAX_Q_OUT_EN
    check("midrst_maxq",  max_q_out, 0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("postrst_valid", act_valid, 0);
    end

    do_start(1'b0, 10'h0, -8, -7, -6, -5, 1'b1);
    wait_result("recover", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
